// File: rtl/adc_deser_pkg.sv
// Shared types and sizing helpers for the ADC serial-frame deserializer.
package adc_deser_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEARCH = 3'd1,
    VERIFY = 3'd2,
    LOCKED = 3'd3,
    FAIL   = 3'd4
  } lane_state_t;

  // Bits per frame on one lane.
  function automatic int unsigned frame_len(input int unsigned ch, input int unsigned sw);
    return ch * sw;
  endfunction

  // Width needed to hold any bit offset 0..f-1.
  function automatic int unsigned slip_w(input int unsigned f);
    return (f < 2) ? 1 : $clog2(f);
  endfunction

endpackage

// File: rtl/adc_lane_align.sv
// One lane: 2-bit/cycle shift window, bit-offset extraction and training-pattern alignment FSM.
module adc_lane_align
  import adc_deser_pkg::*;
#(
  parameter int unsigned  F             = 24,
  parameter logic [F-1:0] TRAIN_PATTERN = 24'hFC0FC0,
  parameter int unsigned  LOCK_FRAMES   = 4,
  parameter int unsigned  SETTLE_FRAMES = 1,
  localparam int unsigned SLIP_W        = slip_w(F)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_strobe,
  input  logic              i_align_start,
  input  logic [1:0]        i_d,
  output logic [F-1:0]      o_word_c,
  output logic              o_locked,
  output logic              o_fail,
  output logic [SLIP_W-1:0] o_slip
);

  // Window reaches back F-1 bits beyond the newest frame; the two newest bits come straight from i_d.
  localparam int unsigned WIN_W = 2 * F - 1;
  localparam int unsigned CNT_W = $clog2(LOCK_FRAMES + 1);
  localparam int unsigned SET_W = (SETTLE_FRAMES < 1) ? 1 : $clog2(SETTLE_FRAMES + 1);

  logic [WIN_W-3:0]  r_sh;
  logic [WIN_W-1:0]  w_win;
  logic [F-1:0]      w_word;
  logic              w_match;
  logic              w_do_slip;
  lane_state_t       r_state,  w_state_nxt;
  logic [SLIP_W-1:0] r_slip,   w_slip_nxt;
  logic [CNT_W-1:0]  r_cnt,    w_cnt_nxt;
  logic [SET_W-1:0]  r_settle, w_settle_nxt;
  logic              r_locked;
  logic              r_fail;

  assign w_win    = {r_sh, i_d};
  assign w_match  = (w_word == TRAIN_PATTERN);
  assign o_word_c = w_word;
  assign o_locked = r_locked;
  assign o_fail   = r_fail;
  assign o_slip   = r_slip;

  // Select the F-bit frame that sits r_slip bits older than the newest bit.
  always_comb begin
    w_word = '0;
    for (int s = 0; s < int'(F); s++) begin
      if (r_slip == SLIP_W'(s)) begin
        w_word = w_win[F-1+s -: F];
      end
    end
  end

  // Alignment FSM next-state: advances only on frame strobes; align_start overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_slip_nxt   = r_slip;
    w_cnt_nxt    = r_cnt;
    w_settle_nxt = r_settle;
    w_do_slip    = 1'b0;
    if (i_align_start) begin
      w_state_nxt  = SEARCH;
      w_slip_nxt   = '0;
      w_cnt_nxt    = '0;
      w_settle_nxt = '0;
    end else if (i_strobe) begin
      case (r_state)
        SEARCH, VERIFY: begin
          if (r_settle != '0) begin
            w_settle_nxt = r_settle - SET_W'(1);
          end else if (!w_match) begin
            w_do_slip = 1'b1;
          end else if (r_state == SEARCH) begin
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = (LOCK_FRAMES == 1) ? LOCKED : VERIFY;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(LOCK_FRAMES - 1)) begin
              w_state_nxt = LOCKED;
            end
          end
        end
        default: ;
      endcase
      if (w_do_slip) begin
        w_cnt_nxt = '0;
        if (r_slip == SLIP_W'(F - 1)) begin
          w_state_nxt = FAIL;
        end else begin
          w_state_nxt  = SEARCH;
          w_slip_nxt   = r_slip + SLIP_W'(1);
          w_settle_nxt = SET_W'(SETTLE_FRAMES);
        end
      end
    end
  end

  // Shift window and FSM state registers; status flags track the next state so they appear one cycle after the strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh     <= '0;
      r_state  <= IDLE;
      r_slip   <= '0;
      r_cnt    <= '0;
      r_settle <= '0;
      r_locked <= 1'b0;
      r_fail   <= 1'b0;
    end else begin
      r_sh     <= w_win[WIN_W-3:0];
      r_state  <= w_state_nxt;
      r_slip   <= w_slip_nxt;
      r_cnt    <= w_cnt_nxt;
      r_settle <= w_settle_nxt;
      r_locked <= (w_state_nxt == LOCKED);
      r_fail   <= (w_state_nxt == FAIL);
    end
  end

endmodule

// File: rtl/adc_frame_deser.sv
// Multi-lane ADC serial-frame deserializer: frame timing, per-lane alignment and registered sample output.
module adc_frame_deser
  import adc_deser_pkg::*;
#(
  parameter int unsigned                     N_LANES       = 32,
  parameter int unsigned                     CH_PER_LANE   = 2,
  parameter int unsigned                     SAMPLE_W      = 12,
  parameter logic [CH_PER_LANE*SAMPLE_W-1:0] TRAIN_PATTERN = 24'hFC0FC0,
  parameter int unsigned                     LOCK_FRAMES   = 4,
  parameter int unsigned                     SETTLE_FRAMES = 1,
  localparam int unsigned                    F             = frame_len(CH_PER_LANE, SAMPLE_W),
  localparam int unsigned                    SLIP_W        = slip_w(F)
) (
  input  logic                                     i_dclk,
  input  logic                                     i_rst,
  input  logic [N_LANES-1:0][1:0]                  i_lane_d,
  input  logic                                     i_align_start,
  output logic                                     o_frame_strobe,
  output logic                                     o_data_valid,
  output logic [N_LANES*CH_PER_LANE*SAMPLE_W-1:0]  o_data_out,
  output logic [N_LANES-1:0]                       o_lane_locked,
  output logic [N_LANES-1:0]                       o_lane_fail,
  output logic [N_LANES*SLIP_W-1:0]                o_lane_slip
);

  localparam int unsigned FPC    = F / 2;
  localparam int unsigned FCNT_W = (FPC < 2) ? 1 : $clog2(FPC);
  localparam int unsigned OUT_W  = N_LANES * CH_PER_LANE * SAMPLE_W;

  logic [FCNT_W-1:0]         r_fcnt;
  logic [FCNT_W-1:0]         w_fcnt_nxt;
  logic                      r_strobe;
  logic [N_LANES-1:0][F-1:0] w_word;
  logic [OUT_W-1:0]          w_samples;
  logic                      w_all_locked;
  logic                      r_data_valid;
  logic [OUT_W-1:0]          r_data_out;

  assign w_fcnt_nxt     = (r_fcnt == FCNT_W'(FPC - 1)) ? '0 : r_fcnt + FCNT_W'(1);
  assign w_all_locked   = &o_lane_locked;
  assign o_frame_strobe = r_strobe;
  assign o_data_valid   = r_data_valid;
  assign o_data_out     = r_data_out;

  // Free-running frame counter; the strobe is registered so it is high exactly while the counter sits at FPC-1.
  always_ff @(posedge i_dclk) begin
    if (i_rst) begin
      r_fcnt   <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_fcnt   <= w_fcnt_nxt;
      r_strobe <= (w_fcnt_nxt == FCNT_W'(FPC - 1));
    end
  end

  for (genvar j = 0; j < int'(N_LANES); j++) begin : g_lane
    adc_lane_align #(
      .F             (F),
      .TRAIN_PATTERN (TRAIN_PATTERN),
      .LOCK_FRAMES   (LOCK_FRAMES),
      .SETTLE_FRAMES (SETTLE_FRAMES)
    ) u_lane (
      .i_clk         (i_dclk),
      .i_rst         (i_rst),
      .i_strobe      (r_strobe),
      .i_align_start (i_align_start),
      .i_d           (i_lane_d[j]),
      .o_word_c      (w_word[j]),
      .o_locked      (o_lane_locked[j]),
      .o_fail        (o_lane_fail[j]),
      .o_slip        (o_lane_slip[j*SLIP_W +: SLIP_W])
    );

    // Word MSBs are channel 0 of the lane; channel c = j*CH_PER_LANE+k occupies sample slot c.
    for (genvar k = 0; k < int'(CH_PER_LANE); k++) begin : g_ch
      assign w_samples[(j*CH_PER_LANE+k)*SAMPLE_W +: SAMPLE_W] = w_word[j][F-1-k*SAMPLE_W -: SAMPLE_W];
    end
  end

  // Capture all channels on a strobe only when every lane is locked; otherwise hold the last samples.
  always_ff @(posedge i_dclk) begin
    if (i_rst) begin
      r_data_valid <= 1'b0;
      r_data_out   <= '0;
    end else begin
      r_data_valid <= r_strobe && w_all_locked;
      if (r_strobe && w_all_locked) begin
        r_data_out <= w_samples;
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_deser.sv
// Directed bench for adc_frame_deser: lane streams are built from per-lane frame words and bit offsets.
module tb_adc_frame_deser;

  localparam int N_LANES = 32;
  localparam int SW      = 12;
  localparam int F       = 24;
  localparam int FPC     = 12;
  localparam int SLIP_W  = 5;
  localparam logic [F-1:0] PAT = 24'hFC0FC0;

  logic                        clk = 1'b0;
  logic                        i_rst;
  logic [N_LANES-1:0][1:0]     i_lane_d;
  logic                        i_align_start;
  logic                        o_frame_strobe;
  logic                        o_data_valid;
  logic [N_LANES*2*SW-1:0]     o_data_out;
  logic [N_LANES-1:0]          o_lane_locked;
  logic [N_LANES-1:0]          o_lane_fail;
  logic [N_LANES*SLIP_W-1:0]   o_lane_slip;

  // Frame word each lane repeats, and the window offset (in bits, older) at which it lines up.
  logic [F-1:0] lane_word [N_LANES];
  int           lane_off  [N_LANES];

  int cyc;
  int c0;
  int n_chk;
  int n_pass;

  always #5 clk = ~clk;

  adc_frame_deser u_dut (
    .i_dclk         (clk),
    .i_rst          (i_rst),
    .i_lane_d       (i_lane_d),
    .i_align_start  (i_align_start),
    .o_frame_strobe (o_frame_strobe),
    .o_data_valid   (o_data_valid),
    .o_data_out     (o_data_out),
    .o_lane_locked  (o_lane_locked),
    .o_lane_fail    (o_lane_fail),
    .o_lane_slip    (o_lane_slip)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Stream bit n of lane j: frame position (n + off) mod F, MSB first.
  function automatic logic lane_bit(input int j, input int n);
    int idx;
    logic [F-1:0] w;
    idx = (n + lane_off[j]) % F;
    w   = lane_word[j];
    return w[F-1-idx];
  endfunction

  function automatic logic [SW-1:0] ch(input int c);
    return o_data_out[c*SW +: SW];
  endfunction

  function automatic logic [SLIP_W-1:0] slip(input int j);
    return o_lane_slip[j*SLIP_W +: SLIP_W];
  endfunction

  // One clock: drive this cycle's lane bits, advance, then check the strobe against the bench's frame phase.
  task automatic tick(input logic start);
    i_align_start = start;
    for (int j = 0; j < N_LANES; j++) begin
      i_lane_d[j] = {lane_bit(j, 2*cyc), lane_bit(j, 2*cyc + 1)};
    end
    @(posedge clk);
    #1;
    if (i_rst) cyc = 0;
    else       cyc++;
    i_align_start = 1'b0;
    chk("strobe", 64'(o_frame_strobe), 64'((cyc % FPC) == FPC - 1));
  endtask

  task automatic start_align();
    while ((cyc % FPC) != 0) tick(1'b0);
    c0 = cyc;
    tick(1'b1);
  endtask

  task automatic run_to(input int off);
    while (cyc < c0 + off) tick(1'b0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; c0 = 0;
    i_rst = 1'b1; i_align_start = 1'b0; i_lane_d = '0;
    for (int j = 0; j < N_LANES; j++) begin
      lane_word[j] = PAT;
      lane_off[j]  = 0;
    end
    repeat (3) tick(1'b0);
    chk("rst_locked", 64'(o_lane_locked), 64'h0);
    chk("rst_valid",  64'(o_data_valid),  64'h0);
    chk("rst_slip0",  64'(slip(0)),       64'h0);
    i_rst = 1'b0;
    repeat (30) tick(1'b0);
    chk("idle_locked", 64'(o_lane_locked), 64'h0);

    // All lanes aligned at offset 0: lock after 4 strobes, samples follow on strobe 5.
    start_align();
    run_to(47);  chk("t1_locked_early", 64'(o_lane_locked), 64'h0);
    run_to(48);  chk("t1_locked",  64'(o_lane_locked), 64'hFFFF_FFFF);
    chk("t1_fail",   64'(o_lane_fail), 64'h0);
    chk("t1_slip0",  64'(slip(0)),  64'h0);
    chk("t1_slip31", 64'(slip(31)), 64'h0);
    run_to(59);  chk("t1_valid_pre", 64'(o_data_valid), 64'h0);
    run_to(60);  chk("t1_valid", 64'(o_data_valid), 64'h1);
    chk("t1_ch0",  64'(ch(0)),  64'hFC0);
    chk("t1_ch63", 64'(ch(63)), 64'hFC0);
    run_to(61);  chk("t1_valid_post", 64'(o_data_valid), 64'h0);

    // Lane 3 needs slip 5: five failed slips at two strobes each, then four matches.
    lane_off[3] = 5;
    start_align();
    run_to(1);   chk("t2_unlock", 64'(o_lane_locked), 64'h0);
    run_to(48);  chk("t2_locked_others", 64'(o_lane_locked), 64'hFFFF_FFF7);
    run_to(60);  chk("t2_valid_gated", 64'(o_data_valid), 64'h0);
    run_to(167); chk("t2_lane3_pending", 64'(o_lane_locked), 64'hFFFF_FFF7);
    chk("t2_slip3_pre", 64'(slip(3)), 64'd5);
    run_to(168); chk("t2_locked_all", 64'(o_lane_locked), 64'hFFFF_FFFF);
    chk("t2_slip3", 64'(slip(3)), 64'd5);
    run_to(180); chk("t2_valid", 64'(o_data_valid), 64'h1);
    chk("t2_ch6", 64'(ch(6)), 64'hFC0);
    chk("t2_ch7", 64'(ch(7)), 64'hFC0);

    // Lane 7 stuck at 0: fails after trying every offset; the rest stay locked.
    lane_word[7] = '0;
    start_align();
    run_to(1);   chk("t3_unlock", 64'(o_lane_locked), 64'h0);
    run_to(168); chk("t3_locked", 64'(o_lane_locked), 64'hFFFF_FF7F);
    run_to(563); chk("t3_fail_pre", 64'(o_lane_fail), 64'h0);
    chk("t3_slip7_pre", 64'(slip(7)), 64'd23);
    run_to(564); chk("t3_fail", 64'(o_lane_fail), 64'h80);
    chk("t3_slip7", 64'(slip(7)), 64'd23);
    chk("t3_locked_post", 64'(o_lane_locked), 64'hFFFF_FF7F);
    run_to(576); chk("t3_valid", 64'(o_data_valid), 64'h0);

    // Realign with lane 7 healthy, then send real samples on lanes 0 and 31.
    lane_word[7] = PAT;
    start_align();
    run_to(1);   chk("t4_fail_clr", 64'(o_lane_fail), 64'h0);
    chk("t4_slip7_clr", 64'(slip(7)), 64'h0);
    run_to(168); chk("t4_locked", 64'(o_lane_locked), 64'hFFFF_FFFF);
    lane_word[0]  = 24'h001_002;
    lane_word[31] = 24'h03F_040;
    run_to(179); chk("t4_valid_pre", 64'(o_data_valid), 64'h0);
    run_to(180); chk("t4_valid", 64'(o_data_valid), 64'h1);
    chk("t4_ch0",  64'(ch(0)),  64'h001);
    chk("t4_ch1",  64'(ch(1)),  64'h002);
    chk("t4_ch62", 64'(ch(62)), 64'h03F);
    chk("t4_ch63", 64'(ch(63)), 64'h040);
    chk("t4_ch6",  64'(ch(6)),  64'hFC0);
    run_to(181); chk("t4_valid_post", 64'(o_data_valid), 64'h0);
    chk("t4_hold_ch0", 64'(ch(0)), 64'h001);

    // align_start while locked: drop lock next cycle, relock at the same offsets.
    lane_word[0]  = PAT;
    lane_word[31] = PAT;
    start_align();
    run_to(1);   chk("t5_unlock", 64'(o_lane_locked), 64'h0);
    chk("t5_slip3_clr", 64'(slip(3)), 64'h0);
    run_to(48);  chk("t5_locked_others", 64'(o_lane_locked), 64'hFFFF_FFF7);
    run_to(168); chk("t5_locked_all", 64'(o_lane_locked), 64'hFFFF_FFFF);
    chk("t5_slip3", 64'(slip(3)), 64'd5);
    run_to(180); chk("t5_valid", 64'(o_data_valid), 64'h1);

    // Reset in the middle of a search at slip 9.
    lane_word[7] = '0;
    start_align();
    run_to(204); chk("t6_slip7", 64'(slip(7)), 64'd9);
    chk("t6_locked", 64'(o_lane_locked), 64'hFFFF_FF7F);
    i_rst = 1'b1;
    tick(1'b0);
    chk("t6_rst_locked", 64'(o_lane_locked), 64'h0);
    chk("t6_rst_fail",   64'(o_lane_fail),   64'h0);
    chk("t6_rst_slip7",  64'(slip(7)),       64'h0);
    chk("t6_rst_slip3",  64'(slip(3)),       64'h0);
    chk("t6_rst_valid",  64'(o_data_valid),  64'h0);
    chk("t6_rst_ch0",    64'(ch(0)),         64'h0);
    i_rst = 1'b0;
    repeat (60) tick(1'b0);
    chk("t6_no_relock", 64'(o_lane_locked), 64'h0);
    chk("t6_idle_slip7", 64'(slip(7)), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
